cluster_frame_ctrl: RTL

- Frame-level sequencer for the per-frame cluster locator in the sensor algorithm chain.
- Accepts a frame-available pulse from the upstream frame buffer and issues the start-of-frame pulse to the buffer and locator.
- Holds threshold/size stable for the whole frame from shadow registers, then captures the locator result.
- Exposes config, results, counters and an interrupt over a small Avalon-MM CSR slave.

---
 rtl/cluster_frame_ctrl_if.sv | 26 ++
 rtl/cluster_frame_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_frame_ctrl_if.sv
// cluster_frame_ctrl_if
// Avalon-MM CSR bus between a host (master) and the frame sequencer (slave).
// Read data is registered inside the slave and appears one cycle after csr_read.
interface cluster_frame_ctrl_if;
   logic [2:0]  csr_address;
   logic        csr_write;
   logic [31:0] csr_writedata;
   logic        csr_read;
   logic [31:0] csr_readdata;

   modport master (
      output csr_address,
      output csr_write,
      output csr_writedata,
      output csr_read,
      input  csr_readdata
   );

   modport slave (
      input  csr_address,
      input  csr_write,
      input  csr_writedata,
      input  csr_read,
      output csr_readdata
   );
endinterface

// File: rtl/cluster_frame_ctrl.sv
// cluster_frame_ctrl
// Frame-level sequencer for the per-frame cluster locator. Waits for a
// frame-available pulse, snapshots THRESH/SIZE into the locator shadows,
// pulses frame_start, then waits for the locator result (or a timeout) and
// records it in the CSR block.
// Optional feature: define CLUSTER_CENTRE_EN to add the CENTRE register
// (left + right, half-channel units) at CSR address 7. Without the macro,
// address 7 reads 0 and no adder or register is built.
module cluster_frame_ctrl #(
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [15:0] THRESH_RST     = 16'd54,
   parameter logic [8:0]  SIZE_RST       = 9'd4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   cluster_frame_ctrl_if.slave       csr,
   input  logic                      frame_avail,
   output logic                      frame_start,
   output logic [15:0]               loc_threshold,
   output logic [8:0]                loc_size,
   input  logic                      loc_has_cluster,
   input  logic                      loc_no_cluster,
   input  logic [8:0]                loc_ch_left,
   input  logic [8:0]                loc_ch_right,
   output logic                      busy,
   output logic                      irq
);

   localparam int TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      RUN     = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [TimerW-1:0]  timer_q;

   logic               enable_q, continuous_q, irqEn_q;
   logic               resultValid_q, hasCluster_q, overrun_q, timeout_q, irqPend_q;
   logic [15:0]        thresh_q;
   logic [8:0]         size_q;
   logic [31:0]        result_q;
   logic [31:0]        frameCnt_q, frameCnt_d;
   logic [31:0]        clusterCnt_q, clusterCnt_d;
   logic [15:0]        locThreshold_q;
   logic [8:0]         locSize_q;
   logic               frameStart_q;
   logic [31:0]        readData_q, readMux;

`ifdef CLUSTER_CENTRE_EN
   logic [9:0]         centre_q;
`endif

   logic               armCycle, resultSeen, timeoutHit, captureCycle, overrunHit;
   logic               wrCtrl, wrStatus, wrThresh, wrSize, clrCnt;
   logic [31:0]        wdata;
   logic               unusedBits;

   assign wdata    = csr.csr_writedata;
   assign wrCtrl   = csr.csr_write && (csr.csr_address == 3'd0);
   assign wrStatus = csr.csr_write && (csr.csr_address == 3'd1);
   assign wrThresh = csr.csr_write && (csr.csr_address == 3'd2);
   assign wrSize   = csr.csr_write && (csr.csr_address == 3'd3);
   assign clrCnt   = wrCtrl && wdata[3];

   assign unusedBits = ^wdata[31:16];

   // A new frame arriving while one is already in flight is dropped and flagged.
   assign overrunHit = frame_avail && (state_q != IDLE);

   // State register; reset abandons any frame in flight without a flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and the single-cycle strobes that drive the datapath.
   always_comb begin
      state_d      = state_q;
      armCycle     = 1'b0;
      resultSeen   = 1'b0;
      timeoutHit   = 1'b0;
      captureCycle = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_avail && enable_q) begin
               state_d = ARM;
            end
         end
         ARM: begin
            armCycle = 1'b1;
            state_d  = RUN;
         end
         RUN: begin
            if (loc_has_cluster || loc_no_cluster) begin
               resultSeen = 1'b1;
               state_d    = CAPTURE;
            end else if (timer_q == TimerLast) begin
               timeoutHit = 1'b1;
               state_d    = IDLE;
            end
         end
         CAPTURE: begin
            captureCycle = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // RUN-state watchdog, restarted for every frame while arming.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else if (armCycle) begin
         timer_q <= '0;
      end else if (state_q == RUN) begin
         timer_q <= timer_q + 1'b1;
      end
   end

   // Shadow THRESH/SIZE into the locator and pulse frame_start together on leaving ARM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locThreshold_q <= THRESH_RST;
         locSize_q      <= SIZE_RST;
         frameStart_q   <= 1'b0;
      end else begin
         frameStart_q <= armCycle;
         if (armCycle) begin
            locThreshold_q <= thresh_q;
            locSize_q      <= size_q;
         end
      end
   end

   // Frame counters; a clear written in the same cycle beats the increment.
   always_comb begin
      frameCnt_d   = frameCnt_q;
      clusterCnt_d = clusterCnt_q;
      if (captureCycle) begin
         frameCnt_d = frameCnt_q + 32'd1;
         if (hasCluster_q) begin
            clusterCnt_d = clusterCnt_q + 32'd1;
         end
      end
      if (clrCnt) begin
         frameCnt_d   = '0;
         clusterCnt_d = '0;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frameCnt_q   <= '0;
         clusterCnt_q <= '0;
      end else begin
         frameCnt_q   <= frameCnt_d;
         clusterCnt_q <= clusterCnt_d;
      end
   end

   // CTRL and configuration registers; single-shot mode drops enable after a capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_q     <= 1'b0;
         continuous_q <= 1'b0;
         irqEn_q      <= 1'b0;
         thresh_q     <= THRESH_RST;
         size_q       <= SIZE_RST;
      end else begin
         if (wrCtrl) begin
            enable_q     <= wdata[0];
            continuous_q <= wdata[1];
            irqEn_q      <= wdata[2];
         end
         if (captureCycle && !continuous_q) begin
            enable_q <= 1'b0;
         end
         if (wrThresh) begin
            thresh_q <= wdata[15:0];
         end
         if (wrSize) begin
            size_q <= wdata[8:0];
         end
      end
   end

   // Sticky STATUS flags; a hardware set in the same cycle as a W1C keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resultValid_q <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_q     <= 1'b0;
         irqPend_q     <= 1'b0;
      end else begin
         if (wrStatus && wdata[1]) resultValid_q <= 1'b0;
         if (wrStatus && wdata[3]) overrun_q     <= 1'b0;
         if (wrStatus && wdata[4]) timeout_q     <= 1'b0;
         if (wrStatus && wdata[5]) irqPend_q     <= 1'b0;
         if (captureCycle) begin
            resultValid_q <= 1'b1;
            irqPend_q     <= 1'b1;
         end
         if (overrunHit) overrun_q <= 1'b1;
         if (timeoutHit) timeout_q <= 1'b1;
      end
   end

   // Latch the locator result on its first valid cycle so RESULT is readable one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q     <= '0;
         hasCluster_q <= 1'b0;
      end else if (resultSeen) begin
         hasCluster_q <= loc_has_cluster;
         if (loc_has_cluster) begin
            result_q <= {7'd0, loc_ch_right, 7'd0, loc_ch_left};
         end else begin
            result_q <= '0;
         end
      end
   end

`ifdef CLUSTER_CENTRE_EN
   // Cluster centre in half-channel units, captured alongside RESULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         centre_q <= '0;
      end else if (resultSeen) begin
         if (loc_has_cluster) begin
            centre_q <= {1'b0, loc_ch_left} + {1'b0, loc_ch_right};
         end else begin
            centre_q <= '0;
         end
      end
   end
`endif

   // CSR read multiplexer; unmapped bits read as zero.
   always_comb begin
      readMux = '0;
      case (csr.csr_address)
         3'd0: readMux = {29'd0, irqEn_q, continuous_q, enable_q};
         3'd1: readMux = {26'd0, irqPend_q, timeout_q, overrun_q, hasCluster_q,
                          resultValid_q, busy};
         3'd2: readMux = {16'd0, thresh_q};
         3'd3: readMux = {23'd0, size_q};
         3'd4: readMux = result_q;
         3'd5: readMux = frameCnt_q;
         3'd6: readMux = clusterCnt_q;
`ifdef CLUSTER_CENTRE_EN
         3'd7: readMux = {22'd0, centre_q};
`else
         3'd7: readMux = '0;
`endif
         default: readMux = '0;
      endcase
   end

   // Registered read data, valid the cycle after csr_read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         readData_q <= '0;
      end else if (csr.csr_read) begin
         readData_q <= readMux;
      end else begin
         readData_q <= '0;
      end
   end

   assign csr.csr_readdata = readData_q;
   assign frame_start      = frameStart_q;
   assign loc_threshold    = locThreshold_q;
   assign loc_size         = locSize_q;
   assign busy             = (state_q != IDLE);
   assign irq              = irqPend_q & irqEn_q;

endmodule
